// File: rtl/branch_predictor_btb_if.sv
// Fetch-side lookup and execute-side update signals between the core and the branch predictor.
interface branch_predictor_btb_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pred_next_pc;
  logic            pred_taken;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_mispredict;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_next_pc, pred_taken
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_next_pc, pred_taken
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating counters: zero-latency next-PC prediction,
// trained from resolved branches, plus branch/mispredict performance counters.
module branch_predictor_btb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned MODE    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  branch_predictor_btb_if.slave bp,
  output logic [31:0]          perf_branches,
  output logic [31:0]          perf_mispred
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;

  typedef logic [CTR_W-1:0] ctr_t;
  localparam ctr_t CTR_MAX = '1;
  localparam ctr_t CTR_WNT = ctr_t'((1 << (CTR_W - 1)) - 1);
  localparam ctr_t CTR_WT  = ctr_t'(1 << (CTR_W - 1));

  logic             valid   [ENTRIES];
  logic [TAG_W-1:0] tags    [ENTRIES];
  logic [XLEN-1:0]  targets [ENTRIES];
  ctr_t             ctrs    [ENTRIES];

  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  logic [IDX_W-1:0] fidx;
  logic [TAG_W-1:0] ftag;
  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             fhit;
  logic             uhit;
  logic             taken;
  logic             unused_pc_bits;

  assign fidx = bp.fetch_pc[IDX_W+1:2];
  assign ftag = bp.fetch_pc[TAG_LO+TAG_W-1:TAG_LO];
  assign uidx = bp.upd_pc[IDX_W+1:2];
  assign utag = bp.upd_pc[TAG_LO+TAG_W-1:TAG_LO];
  assign unused_pc_bits = ^bp.upd_pc;

  always_comb begin
    fhit  = valid[fidx] && (tags[fidx] == ftag);
    uhit  = valid[uidx] && (tags[uidx] == utag);
    taken = (MODE != 0) && fhit && ctrs[fidx][CTR_W-1];
  end

  assign bp.pred_taken   = taken;
  assign bp.pred_next_pc = taken ? targets[fidx] : bp.fetch_pc + XLEN'(4);
  assign perf_branches   = br_cnt;
  assign perf_mispred    = mis_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid[i]   <= 1'b0;
        tags[i]    <= '0;
        targets[i] <= '0;
        ctrs[i]    <= CTR_WNT;
      end
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (bp.upd_valid && !stall) begin
      br_cnt <= br_cnt + 32'd1;
      if (bp.upd_mispredict) mis_cnt <= mis_cnt + 32'd1;
      if (MODE != 0) begin
        if (uhit) begin
          if (bp.upd_taken) begin
            if (ctrs[uidx] != CTR_MAX) ctrs[uidx] <= ctrs[uidx] + ctr_t'(1);
            targets[uidx] <= bp.upd_target;
          end else if (ctrs[uidx] != '0) begin
            ctrs[uidx] <= ctrs[uidx] - ctr_t'(1);
          end
        end else if (bp.upd_taken) begin
          // Direct-mapped: a taken miss always evicts whatever sits at this index.
          valid[uidx]   <= 1'b1;
          tags[uidx]    <= utag;
          targets[uidx] <= bp.upd_target;
          ctrs[uidx]    <= CTR_WT;
        end
      end
    end
  end
endmodule
